// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl
// Per-run sequencer for a streaming FFT core. Each run resets the core,
// pushes the direction word on its config channel, then gates upstream
// samples into the core with a generated tlast every N beats. It keeps
// counting completed output frames until the requested frame count is
// reached, or until a stop request arrives.
//
// Ports
//   clock, resetn         : single clock, synchronous active-low reset
//   start/inverse/frames  : run request, direction (1 = inverse) and frame
//                           count (0 = run until stop), sampled at start
//   stop                  : ends a continuous run at a frame boundary
//   fft_resetn            : drives the core's aresetn
//   cfg_tdata/valid/ready : core config channel, LSB 1 = forward
//   in_t*                 : upstream sample stream
//   fft_t*                : core data input stream
//   out_tvalid/out_tlast  : monitor of the core output (its tready is tied 1)
//   event_tlast_*         : core event flags, folded into err
//   busy/done/err         : run status; err is sticky until the next start
//   frame_cnt             : output frames completed in the current run
module fft_frame_ctrl #(
  parameter int NFFT_LOG2  = 8,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              inverse,
  input  logic [15:0]       frames,
  input  logic              stop,
  output logic              fft_resetn,
  output logic [7:0]        cfg_tdata,
  output logic              cfg_tvalid,
  input  logic              cfg_tready,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [DATA_W-1:0] fft_tdata,
  output logic              fft_tvalid,
  input  logic              fft_tready,
  output logic              fft_tlast,
  input  logic              out_tvalid,
  input  logic              out_tlast,
  input  logic              event_tlast_unexpected,
  input  logic              event_tlast_missing,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE_RST,
    S_CONFIG,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                 state;
  logic                   inverse_q;
  logic [15:0]            frames_q;
  logic                   stop_q;
  logic [NFFT_LOG2-1:0]   in_cnt;
  logic [15:0]            in_frames;
  logic [RC_W-1:0]        rst_cnt;
  logic [WD_W-1:0]        wd_cnt;

  logic run, hs, last_beat, frame_out;

  // Data path is a pure gate in RUN so the core sees the source with no
  // added latency; every other state blocks both directions.
  assign run        = (state == S_RUN);
  assign fft_tvalid = run & in_tvalid;
  assign in_tready  = run & fft_tready;
  assign fft_tdata  = run ? in_tdata : '0;
  assign last_beat  = &in_cnt;
  assign fft_tlast  = fft_tvalid & last_beat;
  assign hs         = fft_tvalid & fft_tready;
  assign cfg_tdata  = {7'b0, ~inverse_q};
  assign frame_out  = out_tvalid & out_tlast;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      inverse_q  <= 1'b0;
      frames_q   <= '0;
      stop_q     <= 1'b0;
      in_cnt     <= '0;
      in_frames  <= '0;
      rst_cnt    <= '0;
      wd_cnt     <= '0;
      fft_resetn <= 1'b0;
      cfg_tvalid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (busy && (event_tlast_unexpected || event_tlast_missing)) err <= 1'b1;
      if ((state == S_RUN || state == S_DRAIN) && frame_out) frame_cnt <= frame_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          fft_resetn <= 1'b1;
          // A start coinciding with the done pulse belongs to the old run.
          if (start && !done) begin
            inverse_q  <= inverse;
            frames_q   <= frames;
            err        <= 1'b0;
            frame_cnt  <= '0;
            in_cnt     <= '0;
            in_frames  <= '0;
            stop_q     <= 1'b0;
            rst_cnt    <= '0;
            busy       <= 1'b1;
            fft_resetn <= 1'b0;
            state      <= S_CORE_RST;
          end
        end

        S_CORE_RST: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            fft_resetn <= 1'b1;
            cfg_tvalid <= 1'b1;
            state      <= S_CONFIG;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_CONFIG: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            state      <= S_RUN;
          end
        end

        S_RUN: begin
          wd_cnt <= '0;  // watchdog starts fresh on DRAIN entry
          if (stop) stop_q <= 1'b1;
          if (hs) begin
            in_cnt <= in_cnt + 1'b1;
            if (last_beat) begin
              in_frames <= in_frames + 16'd1;
              if ((frames_q != 16'd0 && in_frames + 16'd1 == frames_q) || stop_q)
                state <= S_DRAIN;
            end
          end else if (stop_q && in_cnt == '0) begin
            // Sitting on a frame boundary: nothing partial to finish.
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (frame_cnt == in_frames) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (out_tvalid) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl. A data driver supplies random
// samples (optionally with random valid/ready backpressure), a monitor
// scores every core-side beat against a beat-count model and plays the
// FFT core by returning one out_tlast a fixed latency after each input
// frame, and a linear directed sequence runs the scenarios.
module tb_fft_frame_ctrl;
  localparam int NL  = 8;
  localparam int N   = 1 << NL;
  localparam int DW  = 32;
  localparam int RC  = 2;
  localparam int TO  = 16;
  localparam int LAT = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          inverse = 1'b0;
  logic [15:0]   frames = '0;
  logic          stop = 1'b0;
  logic          fft_resetn;
  logic [7:0]    cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic [DW-1:0] fft_tdata;
  logic          fft_tvalid;
  logic          fft_tready = 1'b0;
  logic          fft_tlast;
  logic          out_tvalid = 1'b0;
  logic          out_tlast = 1'b0;
  logic          ev_unexp = 1'b0;
  logic          ev_miss = 1'b0;
  logic          busy, done, err;
  logic [15:0]   frame_cnt;

  fft_frame_ctrl #(.NFFT_LOG2(NL), .DATA_W(DW), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .start(start), .inverse(inverse), .frames(frames),
    .stop(stop), .fft_resetn(fft_resetn), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .event_tlast_unexpected(ev_unexp),
    .event_tlast_missing(ev_miss), .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt));

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Controls owned by the directed sequence.
  bit bp_en   = 1'b0;
  bit core_en = 1'b1;
  int stop_at = -1;
  int run_gen = 0;

  // Model state owned by the monitor.
  int seen_gen = 0;
  int hs_cnt = 0, tl_cnt = 0, out_cnt = 0;
  int last_tl_cyc = 0, last_out_cyc = 0;
  int core_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source and sink: new random sample every cycle, optional backpressure.
  initial forever begin
    @(posedge clock); #1;
    in_tdata   = $urandom;
    in_tvalid  = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    fft_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor + core model: sampled mid-cycle, drives stop and the core output.
  initial forever begin
    @(negedge clock);
    if (run_gen != seen_gen) begin
      seen_gen = run_gen;
      hs_cnt = 0; tl_cnt = 0; out_cnt = 0;
      core_q.delete();
    end
    if (fft_tvalid) begin
      chk("tlast", fft_tlast, (hs_cnt % N) == N - 1);
      chk("tdata", fft_tdata, in_tdata);
    end else begin
      chk("tlast_idle", fft_tlast, 0);
    end
    stop = 1'b0;
    if (fft_tvalid && fft_tready) begin
      if (hs_cnt == stop_at) stop = 1'b1;
      if ((hs_cnt % N) == N - 1) begin
        tl_cnt++;
        last_tl_cyc = cyc;
        if (core_en) core_q.push_back(cyc + LAT);
      end
      hs_cnt++;
    end
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    if (core_q.size() > 0 && core_q[0] <= cyc) begin
      void'(core_q.pop_front());
      out_tvalid = 1'b1;
      out_tlast  = 1'b1;
      out_cnt++;
      last_out_cyc = cyc;
    end
  end

  task automatic do_start(input bit inv, input int fr, input int hold);
    logic [15:0] f;
    f = fr[15:0];
    @(negedge clock);
    start = 1'b1; inverse = inv; frames = f; run_gen++;
    for (int i = 0; i < RC; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i == 0) chk("err_clr", err, 0);
      chk("rst_busy", busy, 1);
      chk("rst_fft_resetn", fft_resetn, 0);
      chk("rst_gate", {fft_tvalid, in_tready}, 0);
    end
    for (int k = 0; k <= hold; k++) begin
      @(negedge clock);
      chk("cfg_tvalid", cfg_tvalid, 1);
      chk("cfg_tdata", cfg_tdata, {7'b0, ~inv});
      chk("cfg_fft_resetn", fft_resetn, 1);
      chk("cfg_gate", {fft_tvalid, in_tready}, 0);
      cfg_tready = (k == hold);
    end
    @(negedge clock);
    cfg_tready = 1'b0;
    chk("cfg_drop", cfg_tvalid, 0);
  endtask

  task automatic wait_done(input int budget, output int dc);
    int n;
    n = 0;
    while (n < budget && done !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", done, 1);
    chk("done_busy", busy, 0);
    dc = cyc;
    #1;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk("hs_reach", hs_cnt >= target, 1);
  endtask

  initial begin
    int dc;
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_fft_resetn", fft_resetn, 0);
    chk("rst_cfg_tdata", cfg_tdata, 8'h01);
    chk("rst_status", {busy, done, err, cfg_tvalid}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_gates", {fft_tvalid, in_tready, fft_tlast}, 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_fft_resetn", fft_resetn, 1);
    chk("post_rst_busy", busy, 0);

    // Forward, 2 frames, no backpressure
    do_start(1'b0, 2, 0);
    wait_done(3000, dc);
    chk("r1_hs", hs_cnt, 512);
    chk("r1_tlast", tl_cnt, 2);
    chk("r1_frame_cnt", frame_cnt, 2);
    chk("r1_done_after_out", dc > last_out_cyc, 1);
    chk("r1_err", err, 0);
    start = 1'b1;  // same cycle as done: must be ignored
    @(negedge clock);
    start = 1'b0;
    chk("r1_done_pulse", done, 0);
    chk("r1_start_ignored", busy, 0);
    @(negedge clock);
    chk("r1_still_idle", busy, 0);

    // Inverse, config held off 5 cycles
    do_start(1'b1, 1, 5);
    wait_done(2000, dc);
    chk("r2_hs", hs_cnt, 256);
    chk("r2_frame_cnt", frame_cnt, 1);

    // Continuous run stopped mid frame 3, with backpressure
    bp_en = 1'b1;
    stop_at = 2 * N + 100;
    do_start(1'b0, 0, 0);
    wait_done(6000, dc);
    stop_at = -1;
    chk("r3_hs", hs_cnt, 3 * N);
    chk("r3_tlast", tl_cnt, 3);
    chk("r3_frame_cnt", frame_cnt, 3);

    // Backpressure, 3 frames
    do_start(1'b0, 3, 0);
    wait_done(6000, dc);
    bp_en = 1'b0;
    chk("r4_hs", hs_cnt, 3 * N);
    chk("r4_tlast", tl_cnt, 3);
    chk("r4_frame_cnt", frame_cnt, out_cnt);
    chk("r4_err", err, 0);

    // No core output: watchdog
    core_en = 1'b0;
    do_start(1'b0, 1, 0);
    wait_done(2000, dc);
    chk("r5_timeout_cycle", dc, last_tl_cyc + 1 + TO);
    chk("r5_err", err, 1);
    chk("r5_frame_cnt", frame_cnt, 0);
    repeat (3) @(negedge clock);
    chk("r5_err_sticky", err, 1);
    core_en = 1'b1;

    // Core event flag in RUN
    do_start(1'b0, 1, 0);
    wait_hs(50);
    ev_miss = 1'b1;
    @(negedge clock);
    ev_miss = 1'b0;
    chk("r6_err_set", err, 1);
    wait_done(2000, dc);
    chk("r6_err_held", err, 1);
    chk("r6_frame_cnt", frame_cnt, 1);

    // Reset mid-run, then a clean run
    do_start(1'b0, 2, 0);
    wait_hs(100);
    resetn = 1'b0;
    @(negedge clock);
    chk("r7_busy", busy, 0);
    chk("r7_fft_resetn_low", fft_resetn, 0);
    chk("r7_frame_cnt", frame_cnt, 0);
    chk("r7_gates", {fft_tvalid, in_tready, cfg_tvalid}, 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("r7_fft_resetn_high", fft_resetn, 1);
    chk("r7_idle", busy, 0);
    do_start(1'b0, 1, 0);
    wait_done(2000, dc);
    chk("r7_hs", hs_cnt, 256);
    chk("r7_frame_cnt_new", frame_cnt, 1);
    chk("r7_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
